// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit
//   Instruction-fetch front end. It issues in-order reads to a variable-latency
//   instruction memory and keeps the returned words, each tagged with its PC, in
//   a DEPTH-entry prefetch FIFO. The FIFO head drives the IF_ID register. Decode
//   back-pressure (stall) and branch/jump redirects are handled here, and data
//   still in flight from the wrong path is thrown away.
//   When no valid instruction is available, instr shows the bubble encoding
//   (all ones).
//
// Ports
//   clock, reset                 rising-edge clock, asynchronous active-high reset
//   imem_req/imem_addr           read request and address (address = fetch_pc)
//   imem_ready                   memory accepts the request this cycle
//   imem_rvalid/imem_rdata       in-order read response
//   stall                        downstream cannot take an instruction this cycle
//   redirect/redirect_pc         taken branch/jump: flush and refetch from redirect_pc
//   instr_valid/instr/instr_pc   FIFO head, or bubble/0 when the FIFO is empty
//   fifo_count                   entries currently buffered
module fetch_prefetch_unit #(
  parameter int unsigned     PC_W     = 8,
  parameter int unsigned     INSTR_W  = 16,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [PC_W-1:0]        imem_addr,
  input  logic                   imem_ready,
  input  logic                   imem_rvalid,
  input  logic [INSTR_W-1:0]     imem_rdata,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [PC_W-1:0]        redirect_pc,
  output logic                   instr_valid,
  output logic [INSTR_W-1:0]     instr,
  output logic [PC_W-1:0]        instr_pc,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PC_W-1:0]    fetch_pc;
  logic [PC_W-1:0]    resp_pc;
  logic [INSTR_W-1:0] data_mem [DEPTH];
  logic [PC_W-1:0]    pc_mem   [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   outstanding;
  logic [CNT_W-1:0]   discard;

  logic [CNT_W:0]     in_use;
  logic               handshake;
  logic               resp;
  logic               accept;
  logic               pop;
  logic [CNT_W-1:0]   out_next;

  always_comb begin
    // A request is issued only if the FIFO has room for every in-flight word.
    // This keeps the FIFO from ever overflowing.
    in_use      = {1'b0, outstanding} + {1'b0, count};
    imem_req    = ~reset & ~redirect & (in_use < (CNT_W+1)'(DEPTH));
    imem_addr   = fetch_pc;
    handshake   = imem_req & imem_ready;
    // A response while nothing is outstanding is a protocol error, so it is ignored.
    resp        = imem_rvalid & (outstanding != '0);
    accept      = resp & (discard == '0) & ~redirect;
    instr_valid = (count != '0);
    pop         = instr_valid & ~stall & ~redirect;
    out_next    = outstanding + CNT_W'(handshake) - CNT_W'(resp);
    instr       = instr_valid ? data_mem[rd_ptr] : '1;
    instr_pc    = instr_valid ? pc_mem[rd_ptr]   : '0;
    fifo_count  = count;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= out_next;
      if (redirect) begin
        // Every word still in flight after this cycle belongs to the wrong path.
        fetch_pc <= redirect_pc;
        resp_pc  <= redirect_pc;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        discard  <= out_next;
      end else begin
        if (handshake) fetch_pc <= fetch_pc + PC_W'(1);
        if (resp) begin
          if (discard != '0) discard <= discard - CNT_W'(1);
          else               resp_pc <= resp_pc + PC_W'(1);
        end
        if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + CNT_W'(accept) - CNT_W'(pop);
      end
    end
  end

  // The storage has no reset. Entries are only ever read behind a valid count.
  always_ff @(posedge clock) begin
    if (accept) begin
      data_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]   <= resp_pc;
    end
  end

endmodule
